bubble_sort_master: RTL

//  Bus master that drives the memory block's AR/R/AW/W/B port and sorts words [0..len-1]
//  in place, ascending, unsigned, using bubble sort.

---
 rtl/bubble_sort_master.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/bubble_sort_master.sv
// Bus master that sorts memory words [0..len-1] in place (ascending, unsigned)
// with bubble sort over an AR/R/AW/W/B port, one transaction outstanding at a time.
module bubble_sort_master #(
  parameter int ADDR_WDTH = 4,
  parameter int DATA_WDTH = 32,
  parameter int RESP_WDTH = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [ADDR_WDTH:0]   len,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic                 ar_valid,
  input  logic                 ar_ready,
  output logic [ADDR_WDTH-1:0] ar_address,
  input  logic                 r_valid,
  output logic                 r_ready,
  input  logic [RESP_WDTH-1:0] r_resp,
  input  logic [DATA_WDTH-1:0] r_data,
  output logic                 aw_valid,
  input  logic                 aw_ready,
  output logic [ADDR_WDTH-1:0] aw_address,
  output logic                 w_valid,
  input  logic                 w_ready,
  output logic [DATA_WDTH-1:0] w_data,
  input  logic                 b_valid,
  output logic                 b_ready,
  input  logic [RESP_WDTH-1:0] b_resp
);

  typedef enum logic [2:0] {
    S_IDLE, S_RD_AR, S_RD_R, S_CMP, S_WR_AW_W, S_WR_B, S_NEXT, S_DONE
  } state_t;

  localparam logic [ADDR_WDTH:0] L_ONE = (ADDR_WDTH+1)'(1);
  localparam logic [ADDR_WDTH:0] L_TWO = (ADDR_WDTH+1)'(2);

  state_t                 state_q;
  logic [ADDR_WDTH:0]     i_q, last_q;
  logic [DATA_WDTH-1:0]   a_q, b_q;
  logic                   swapped_q, fill_a_q, wr_second_q;
  logic                   busy_q, done_q, error_q;
  logic                   ar_valid_q, r_ready_q, aw_valid_q, w_valid_q, b_ready_q;
  logic [ADDR_WDTH-1:0]   ar_address_q, aw_address_q;
  logic [DATA_WDTH-1:0]   w_data_q;

  logic a_gt_b, aw_fin, w_fin;

  always_comb begin
    a_gt_b = a_q > b_q;
    // A channel is finished once it has transferred earlier or transfers this edge.
    aw_fin = !aw_valid_q || aw_ready;
    w_fin  = !w_valid_q  || w_ready;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      i_q          <= '0;
      last_q       <= '0;
      a_q          <= '0;
      b_q          <= '0;
      swapped_q    <= 1'b0;
      fill_a_q     <= 1'b0;
      wr_second_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      ar_valid_q   <= 1'b0;
      r_ready_q    <= 1'b0;
      aw_valid_q   <= 1'b0;
      w_valid_q    <= 1'b0;
      b_ready_q    <= 1'b0;
      ar_address_q <= '0;
      aw_address_q <= '0;
      w_data_q     <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            error_q <= 1'b0;
            busy_q  <= 1'b1;
            if (len <= L_ONE) begin
              state_q <= S_DONE;
            end else begin
              last_q       <= len - L_ONE;
              i_q          <= '0;
              swapped_q    <= 1'b0;
              fill_a_q     <= 1'b1;
              ar_valid_q   <= 1'b1;
              ar_address_q <= '0;
              state_q      <= S_RD_AR;
            end
          end
        end
        S_RD_AR: begin
          if (ar_ready) begin
            ar_valid_q <= 1'b0;
            r_ready_q  <= 1'b1;
            state_q    <= S_RD_R;
          end
        end
        S_RD_R: begin
          if (r_valid) begin
            r_ready_q <= 1'b0;
            if (r_resp != '0) begin
              error_q <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= S_IDLE;
            end else if (fill_a_q) begin
              a_q          <= r_data;
              fill_a_q     <= 1'b0;
              ar_valid_q   <= 1'b1;
              ar_address_q <= ADDR_WDTH'(i_q + L_ONE);
              state_q      <= S_RD_AR;
            end else begin
              b_q     <= r_data;
              state_q <= S_CMP;
            end
          end
        end
        S_CMP: begin
          if (a_gt_b) begin
            swapped_q    <= 1'b1;
            wr_second_q  <= 1'b0;
            aw_valid_q   <= 1'b1;
            w_valid_q    <= 1'b1;
            aw_address_q <= ADDR_WDTH'(i_q);
            w_data_q     <= b_q;
            state_q      <= S_WR_AW_W;
          end else begin
            state_q <= S_NEXT;
          end
        end
        S_WR_AW_W: begin
          if (aw_valid_q && aw_ready) aw_valid_q <= 1'b0;
          if (w_valid_q && w_ready)   w_valid_q  <= 1'b0;
          if (aw_fin && w_fin) begin
            b_ready_q <= 1'b1;
            state_q   <= S_WR_B;
          end
        end
        S_WR_B: begin
          if (b_valid) begin
            b_ready_q <= 1'b0;
            if (b_resp != '0) begin
              error_q <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= S_IDLE;
            end else if (!wr_second_q) begin
              wr_second_q  <= 1'b1;
              aw_valid_q   <= 1'b1;
              w_valid_q    <= 1'b1;
              aw_address_q <= ADDR_WDTH'(i_q + L_ONE);
              w_data_q     <= a_q;
              state_q      <= S_WR_AW_W;
            end else begin
              state_q <= S_NEXT;
            end
          end
        end
        S_NEXT: begin
          // The larger of the pair now sits at i+1 and becomes the next A.
          a_q <= a_gt_b ? a_q : b_q;
          i_q <= i_q + L_ONE;
          if ((i_q + L_ONE) < last_q) begin
            ar_valid_q   <= 1'b1;
            ar_address_q <= ADDR_WDTH'(i_q + L_TWO);
            state_q      <= S_RD_AR;
          end else begin
            last_q <= last_q - L_ONE;
            if (!swapped_q || last_q == L_ONE) begin
              state_q <= S_DONE;
            end else begin
              swapped_q    <= 1'b0;
              i_q          <= '0;
              fill_a_q     <= 1'b1;
              ar_valid_q   <= 1'b1;
              ar_address_q <= '0;
              state_q      <= S_RD_AR;
            end
          end
        end
        S_DONE: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;
  assign ar_valid   = ar_valid_q;
  assign ar_address = ar_address_q;
  assign r_ready    = r_ready_q;
  assign aw_valid   = aw_valid_q;
  assign aw_address = aw_address_q;
  assign w_valid    = w_valid_q;
  assign w_data     = w_data_q;
  assign b_ready    = b_ready_q;

endmodule
